// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush/grant controller for the 5-stage core: load-use and
// branch-in-decode hazards, I/D fill arbitration on the shared port, HLT drain.
module hazard_stall_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       fd_regRs,
   input  logic [3:0]       fd_regRt,
   input  logic             fd_uses_rs,
   input  logic             fd_uses_rt,
   input  logic             fd_is_branch,
   input  logic             fd_halt,
   input  logic             branch_taken,
   input  logic             de_memread,
   input  logic             de_regwrite,
   input  logic [3:0]       de_dstreg,
   input  logic             em_memread,
   input  logic [3:0]       em_dstreg,
   input  logic             icache_miss,
   input  logic             icache_fill_done,
   input  logic             dcache_miss,
   input  logic             dcache_fill_done,
   output logic             pc_write,
   output logic             fd_write,
   output logic             fd_flush,
   output logic             de_write,
   output logic             de_flush,
   output logic             em_write,
   output logic             mw_write,
   output logic             igrant,
   output logic             dgrant,
   output logic             halt_done,
   output logic [CNT_W-1:0] stall_count
);

   localparam int DCW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {
      S_RUN    = 3'd0,
      S_IFILL  = 3'd1,
      S_DFILL  = 3'd2,
      S_DRAIN  = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [DCW-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic de_nz_s, em_nz_s, load_use_s, br_haz_s, hz_s;

   // R0 is hardwired zero, so a write to it can never create a dependency.
   assign de_nz_s    = (de_dstreg != 4'd0);
   assign em_nz_s    = (em_dstreg != 4'd0);
   assign load_use_s = de_memread & de_nz_s &
                       ((fd_uses_rs & (de_dstreg == fd_regRs)) |
                        (fd_uses_rt & (de_dstreg == fd_regRt)));
   assign br_haz_s   = fd_is_branch & fd_uses_rs &
                       ((de_regwrite & de_nz_s & (de_dstreg == fd_regRs)) |
                        (em_memread  & em_nz_s & (em_dstreg == fd_regRs)));
   assign hz_s       = load_use_s | br_haz_s;

   assign halt_done   = (state_q == S_HALTED);
   assign stall_count = stall_q;

   // Enables, flushes and grants from current state and hazard inputs.
   always_comb begin
      pc_write = 1'b0;
      fd_write = 1'b0;
      fd_flush = 1'b0;
      de_write = 1'b0;
      de_flush = 1'b0;
      em_write = 1'b0;
      mw_write = 1'b0;
      igrant   = 1'b0;
      dgrant   = 1'b0;
      case (state_q)
         S_RUN: begin
            de_write = 1'b1;
            em_write = 1'b1;
            mw_write = 1'b1;
            if (hz_s) begin
               de_flush = 1'b1;
            end else begin
               pc_write = 1'b1;
               fd_write = 1'b1;
               fd_flush = branch_taken;
            end
         end
         S_IFILL: begin
            igrant = 1'b1;
            if (dcache_miss) begin
               pc_write = 1'b0;
            end else if (hz_s) begin
               de_write = 1'b1;
               de_flush = 1'b1;
               em_write = 1'b1;
               mw_write = 1'b1;
            end else begin
               // A taken branch redirects the PC while the fill keeps the port.
               pc_write = branch_taken;
               fd_write = 1'b1;
               fd_flush = 1'b1;
               de_write = 1'b1;
               em_write = 1'b1;
               mw_write = 1'b1;
            end
         end
         S_DFILL: begin
            dgrant = 1'b1;
         end
         S_DRAIN: begin
            if (dcache_miss) begin
               dgrant = 1'b1;
            end else begin
               fd_write = 1'b1;
               fd_flush = 1'b1;
               de_write = 1'b1;
               em_write = 1'b1;
               mw_write = 1'b1;
            end
         end
         S_HALTED: begin
            pc_write = 1'b0;
         end
         default: begin
            pc_write = 1'b0;
         end
      endcase
   end

   // Next state, drain countdown and stall-cycle counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RUN: begin
            if (dcache_miss) begin
               state_d = S_DFILL;
            end else if (icache_miss) begin
               state_d = S_IFILL;
            end else if (fd_halt && !hz_s) begin
               state_d = S_DRAIN;
               cnt_d   = DCW'(DRAIN_CYCLES);
            end else begin
               state_d = S_RUN;
            end
         end
         S_IFILL: begin
            if (icache_fill_done) begin
               state_d = dcache_miss ? S_DFILL : S_RUN;
            end else begin
               state_d = S_IFILL;
            end
         end
         S_DFILL: begin
            if (dcache_fill_done) begin
               state_d = icache_miss ? S_IFILL : S_RUN;
            end else begin
               state_d = S_DFILL;
            end
         end
         S_DRAIN: begin
            if (dcache_miss) begin
               cnt_d = cnt_q;
            end else if (cnt_q <= DCW'(1)) begin
               state_d = S_HALTED;
               cnt_d   = {DCW{1'b0}};
            end else begin
               cnt_d = cnt_q - DCW'(1);
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = {DCW{1'b0}};
         end
      endcase

      if (!pc_write && (state_q != S_HALTED) && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end else begin
         stall_d = stall_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RUN;
         cnt_q   <= {DCW{1'b0}};
         stall_q <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

endmodule
